// File: rtl/conv_psum_acc.sv
// conv_psum_acc: adds systolic results to bias or stored partial sums per lane,
// routing each word to the accumulator buffer or to the scale stage.
module conv_psum_acc #(
   parameter int AW     = 11,
   parameter int DW     = 22,
   parameter int DN     = 6,
   parameter int SAT_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [AW-1:0]    cmd_base1,
   input  logic [AW-1:0]    cmd_base2,
   input  logic [7:0]       cmd_size,
   input  logic             cmd_first,
   input  logic             cmd_last,
   output logic             rd_en,
   output logic [AW-1:0]    m_addr1,
   output logic [AW-1:0]    m_addr2,
   output logic [AW-1:0]    m_addr3,
   input  logic [DW*DN-1:0] m_data1,
   input  logic [DW*DN-1:0] m_data2,
   input  logic [DW*DN-1:0] m_data3,
   output logic [AW-1:0]    wr_addr,
   output logic [DW*DN-1:0] m_sum,
   output logic [DW*DN-1:0] s_sum,
   output logic             m_valid,
   output logic             s_valid,
   output logic             ovf,
   output logic             busy,
   output logic             done
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       r_state;
   logic             r_pv, r_pf, r_pl;
   logic [AW-1:0]    r_pb1, r_pb2;
   logic [7:0]       r_psz;
   logic [AW-1:0]    r_b1, r_b2;
   logic [7:0]       r_sz, r_idx;
   logic             r_f, r_l;
   logic             r_p1v, r_p1f, r_p1l, r_p1lw;
   logic [AW-1:0]    r_p1wa;
   logic             r_ov, r_ol, r_olw, r_ovf, r_done;
   logic [AW-1:0]    r_owa;
   logic [DW*DN-1:0] r_sum;
   logic             w_run, w_acc, w_last_iss, w_drained, w_zero, w_load, w_pop;
   logic [DW*DN-1:0] w_sum;
   logic             w_ovf, w_lo;
   logic [DW:0]      w_x;

   assign w_run      = r_state == RUN;
   assign w_acc      = cmd_valid & ~r_pv;
   assign w_last_iss = w_run & (r_idx == r_sz - 8'd1);
   // the stage-1 check stops an older command's last word from ending DRAIN early
   assign w_drained  = (r_state == DRAIN) & r_ov & r_olw & ~r_p1v;
   assign w_zero     = (r_state == IDLE) & r_pv & (r_psz == 8'd0);
   assign w_load     = r_pv & (r_psz != 8'd0) & ((r_state == IDLE) | (w_last_iss & r_pf) | w_drained);
   assign w_pop      = w_load | w_zero;

   always_comb begin
      w_sum = '0;
      w_ovf = 1'b0;
      w_x   = '0;
      w_lo  = 1'b0;
      for (int i = 0; i < DN; i++) begin
         w_x = {m_data1[i*DW+DW-1], m_data1[i*DW+:DW]} + (r_p1f ? {m_data2[i*DW+DW-1], m_data2[i*DW+:DW]}
                                                                : {m_data3[i*DW+DW-1], m_data3[i*DW+:DW]});
         w_lo = (SAT_EN != 0) && (w_x[DW] != w_x[DW-1]);
         w_sum[i*DW+:DW] = w_lo ? (w_x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : w_x[DW-1:0];
         w_ovf = w_ovf | w_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pv    <= 1'b0;
         r_pf    <= 1'b0;
         r_pl    <= 1'b0;
         r_pb1   <= '0;
         r_pb2   <= '0;
         r_psz   <= '0;
         r_b1    <= '0;
         r_b2    <= '0;
         r_sz    <= '0;
         r_idx   <= '0;
         r_f     <= 1'b0;
         r_l     <= 1'b0;
         r_p1v   <= 1'b0;
         r_p1f   <= 1'b0;
         r_p1l   <= 1'b0;
         r_p1lw  <= 1'b0;
         r_p1wa  <= '0;
         r_ov    <= 1'b0;
         r_ol    <= 1'b0;
         r_olw   <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_owa   <= '0;
         r_sum   <= '0;
      end else begin
         if (w_acc) begin
            r_pb1 <= cmd_base1;
            r_pb2 <= cmd_base2;
            r_psz <= cmd_size;
            r_pf  <= cmd_first;
            r_pl  <= cmd_last;
         end
         r_pv <= w_acc | (r_pv & ~w_pop);
         if (w_load) begin
            r_b1  <= r_pb1;
            r_b2  <= r_pb2;
            r_sz  <= r_psz;
            r_f   <= r_pf;
            r_l   <= r_pl;
            r_idx <= '0;
         end else if (w_run) begin
            r_idx <= r_idx + 8'd1;
         end
         r_state <= w_load ? RUN : w_last_iss ? DRAIN : w_drained ? IDLE : r_state;
         r_p1v   <= w_run;
         r_p1f   <= r_f;
         r_p1l   <= r_l;
         r_p1lw  <= w_last_iss;
         r_p1wa  <= m_addr2;
         r_ov    <= r_p1v;
         r_ovf   <= r_p1v & w_ovf;
         if (r_p1v) begin
            r_sum <= w_sum;
            r_ol  <= r_p1l;
            r_olw <= r_p1lw;
            r_owa <= r_p1wa;
         end
         r_done <= (r_ov & r_olw) | w_zero;
      end
   end

   assign cmd_ready = ~r_pv;
   assign rd_en     = w_run;
   assign m_addr1   = r_b1 + AW'(r_idx);
   assign m_addr2   = r_b2 + AW'(r_idx);
   assign m_addr3   = m_addr2;
   assign wr_addr   = r_owa;
   assign m_sum     = r_sum;
   assign s_sum     = r_sum;
   assign m_valid   = r_ov & ~r_ol;
   assign s_valid   = r_ov & r_ol;
   assign ovf       = r_ovf;
   assign busy      = (r_state != IDLE) | r_pv | r_p1v | r_ov | r_done;
   assign done      = r_done;
endmodule

// File: tb/tb_conv_psum_acc.sv
// tb_conv_psum_acc: scoreboard bench with buffer models, a saturating and a wrapping instance.
module tb_conv_psum_acc;
   localparam int AW = 11;
   localparam int DW = 22;
   localparam int DN = 6;
   localparam int WW = DW * DN;
   localparam int NA = 1 << AW;

   typedef struct {
      logic [WW-1:0] d;
      logic [WW-1:0] dw;
      bit            o;
      logic [AW-1:0] wa;
      bit            l;
      bit            lw;
      bit            f;
      int            id;
   } exp_t;
   typedef struct {
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      bit            f;
      int            id;
   } iss_t;

   logic clk = 1'b0;
   logic rst, cmd_valid, cmd_first, cmd_last, mem_init;
   logic [AW-1:0] cmd_base1, cmd_base2;
   logic [7:0] cmd_size;
   logic cmd_ready, rd_en, m_valid, s_valid, ovf, busy, done;
   logic [AW-1:0] m_addr1, m_addr2, m_addr3, wr_addr;
   logic [WW-1:0] m_data1, m_data2, m_data3, m_sum, s_sum;
   logic x_cmd_ready, x_rd_en, x_m_valid, x_s_valid, x_ovf, x_busy, x_done;
   logic [AW-1:0] x_m_addr1, x_m_addr2, x_m_addr3, x_wr_addr;
   logic [WW-1:0] x_m_sum, x_s_sum;

   logic [WW-1:0] mem1 [NA];
   logic [WW-1:0] mem2 [NA];
   logic [WW-1:0] mem3 [NA];
   logic [WW-1:0] ini3 [NA];
   logic [WW-1:0] ref3 [NA];

   exp_t q0[$];
   exp_t q1[$];
   iss_t qa[$];
   int   lat_q[$];
   int   iss_cyc[$];
   exp_t w, w1;
   iss_t e;
   int checks = 0, errors = 0, cyc = 0, n_iss = 0, n_done = 0, exp_done = 0, cmd_id = 0;
   bit want_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_psum_acc #(.AW(AW), .DW(DW), .DN(DN), .SAT_EN(1)) u_sat (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base1(cmd_base1), .cmd_base2(cmd_base2), .cmd_size(cmd_size),
      .cmd_first(cmd_first), .cmd_last(cmd_last), .rd_en(rd_en),
      .m_addr1(m_addr1), .m_addr2(m_addr2), .m_addr3(m_addr3),
      .m_data1(m_data1), .m_data2(m_data2), .m_data3(m_data3),
      .wr_addr(wr_addr), .m_sum(m_sum), .s_sum(s_sum), .m_valid(m_valid),
      .s_valid(s_valid), .ovf(ovf), .busy(busy), .done(done));

   conv_psum_acc #(.AW(AW), .DW(DW), .DN(DN), .SAT_EN(0)) u_wrap (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(x_cmd_ready),
      .cmd_base1(cmd_base1), .cmd_base2(cmd_base2), .cmd_size(cmd_size),
      .cmd_first(cmd_first), .cmd_last(cmd_last), .rd_en(x_rd_en),
      .m_addr1(x_m_addr1), .m_addr2(x_m_addr2), .m_addr3(x_m_addr3),
      .m_data1(m_data1), .m_data2(m_data2), .m_data3(m_data3),
      .wr_addr(x_wr_addr), .m_sum(x_m_sum), .s_sum(x_s_sum), .m_valid(x_m_valid),
      .s_valid(x_s_valid), .ovf(x_ovf), .busy(x_busy), .done(x_done));

   // buffers: 1-cycle read latency, accumulator written by the saturating instance
   always @(posedge clk) begin
      if (rd_en) begin
         m_data1 <= mem1[m_addr1];
         m_data2 <= mem2[m_addr2];
         m_data3 <= mem3[m_addr3];
      end
      if (mem_init)
         for (int a = 0; a < NA; a++) mem3[a] <= ini3[a];
      else if (m_valid)
         mem3[wr_addr] <= m_sum;
   end

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] rword();
      logic [WW-1:0] r;
      logic [DW-1:0] v;
      r = '0;
      for (int i = 0; i < DN; i++) begin
         case ($urandom_range(0, 3))
            0: v = {1'b0, {(DW-1){1'b1}}} - DW'($urandom_range(0, 2));
            1: v = {1'b1, {(DW-1){1'b0}}} + DW'($urandom_range(0, 2));
            default: v = DW'($urandom);
         endcase
         r[i*DW+:DW] = v;
      end
      return r;
   endfunction

   function automatic logic [WW-1:0] fill(input int v);
      logic [WW-1:0] r;
      for (int i = 0; i < DN; i++) r[i*DW+:DW] = DW'(v);
      return r;
   endfunction

   // reference lane arithmetic: exact integer sum, then clamp or wrap to DW bits
   function automatic void model(input logic [WW-1:0] a, input logic [WW-1:0] b, input bit sat,
                                 output logic [WW-1:0] r, output bit o);
      int x, mx;
      mx = (1 << (DW-1)) - 1;
      o = 0;
      r = '0;
      for (int i = 0; i < DN; i++) begin
         x = int'($signed(a[i*DW+:DW])) + int'($signed(b[i*DW+:DW]));
         if (sat && x > mx) begin x = mx; o = 1; end
         else if (sat && x < -mx - 1) begin x = -mx - 1; o = 1; end
         r[i*DW+:DW] = x[DW-1:0];
      end
   endfunction

   task automatic send(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input int sz, input bit f, input bit l);
      int t;
      exp_t x;
      iss_t s;
      logic [AW-1:0] a1, a2;
      bit ow;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
      if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
      for (int i = 0; i < sz; i++) begin
         a1 = b1 + AW'(i);
         a2 = b2 + AW'(i);
         model(mem1[a1], f ? mem2[a2] : ref3[a2], 1, x.d, x.o);
         model(mem1[a1], f ? mem2[a2] : ref3[a2], 0, x.dw, ow);
         if (!l) ref3[a2] = x.d;
         x.wa = a2; x.l = l; x.lw = (i == sz - 1); x.f = f; x.id = cmd_id;
         q0.push_back(x);
         q1.push_back(x);
         s.a1 = a1; s.a2 = a2; s.f = f; s.id = cmd_id;
         qa.push_back(s);
      end
      cmd_id++;
      exp_done++;
      cmd_valid = 1; cmd_base1 = b1; cmd_base2 = b2; cmd_size = 8'(sz); cmd_first = f; cmd_last = l;
      @(posedge clk);
      #1 cmd_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk);
         #2;
         ok = !busy && cmd_ready && q0.size() == 0 && qa.size() == 0;
      end
      if (!ok) chk("idle_timeout", busy, 0);
   endtask

   task automatic reset_chk(input string nm);
      chk({nm, "_flags"}, {cmd_ready, rd_en, m_valid, s_valid, ovf, busy, done}, 7'b1000000);
      chk({nm, "_addr"}, {m_addr1, m_addr2, m_addr3, wr_addr}, '0);
      chk({nm, "_sum"}, m_sum | s_sum, '0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         qa.delete(); q0.delete(); q1.delete(); lat_q.delete();
         want_done = 0;
      end else begin
         chk("wrap_ctrl", {x_cmd_ready, x_rd_en, x_m_addr1, x_m_addr2, x_m_addr3, x_wr_addr, x_m_valid, x_s_valid, x_busy, x_done},
                          {cmd_ready, rd_en, m_addr1, m_addr2, m_addr3, wr_addr, m_valid, s_valid, busy, done});
         if (want_done) chk("done_timing", done, 1);
         want_done = 0;
         if (done) n_done++;
         if (rd_en) begin
            n_iss++;
            iss_cyc.push_back(cyc);
            if (qa.size() == 0) chk("rd_en_unexpected", rd_en, 0);
            else begin
               e = qa.pop_front();
               chk("m_addr1", m_addr1, e.a1);
               chk("m_addr2", m_addr2, e.a2);
               chk("m_addr3", m_addr3, e.a2);
               lat_q.push_back(cyc);
               if (!e.f && q0.size() > 0) chk("raw_wait", q0[0].id >= e.id, 1);
            end
         end
         if (m_valid || s_valid) begin
            chk("valid_excl", m_valid & s_valid, 0);
            if (q0.size() == 0) chk("out_unexpected", m_valid | s_valid, 0);
            else begin
               w = q0.pop_front();
               chk("m_sum", m_sum, w.d);
               chk("s_sum", s_sum, w.d);
               chk("wr_addr", wr_addr, w.wa);
               chk("ovf", ovf, w.o);
               chk("route", s_valid, w.l);
               if (lat_q.size() > 0) chk("latency", cyc - lat_q.pop_front(), 2);
               if (w.lw) want_done = 1;
            end
         end else chk("ovf_idle", ovf, 0);
         if (x_m_valid || x_s_valid) begin
            chk("wrap_ovf", x_ovf, 0);
            chk("wrap_s_sum", x_s_sum, x_m_sum);
            if (q1.size() > 0) begin
               w1 = q1.pop_front();
               if (w1.f) chk("wrap_sum", x_m_sum, w1.dw);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d errors", errors);
      $fatal(1);
   end

   initial begin
      int d0, i0, n0;
      rst = 1; cmd_valid = 0; cmd_base1 = '0; cmd_base2 = '0; cmd_size = '0;
      cmd_first = 0; cmd_last = 0; mem_init = 0;
      for (int a = 0; a < NA; a++) begin
         mem1[a] = rword();
         mem2[a] = rword();
         ini3[a] = rword();
         ref3[a] = ini3[a];
      end
      for (int a = 0; a < 4; a++) begin
         mem1[11'h010 + a] = fill(5);
         mem2[11'h100 + a] = fill(3);
      end
      mem1[11'h300] = fill(32'h1FFFFF);
      mem2[11'h340] = fill(1);
      mem_init = 1;
      repeat (2) @(posedge clk);
      mem_init = 0;
      @(negedge clk);
      #1 reset_chk("reset");
      rst = 0;

      d0 = n_done;
      send(11'h010, 11'h100, 4, 1, 0);
      wait_idle();
      chk("basic_done", n_done - d0, 1);
      chk("basic_lane", ref3[11'h103][DW-1:0], 8);

      i0 = iss_cyc.size();
      send(11'h010, 11'h180, 3, 1, 0);
      send(11'h020, 11'h200, 3, 1, 1);
      wait_idle();
      chk("chain_issues", iss_cyc.size() - i0, 6);
      if (iss_cyc.size() >= i0 + 6) chk("chain_no_bubble", iss_cyc[i0+5] - iss_cyc[i0], 5);

      send(11'h010, 11'h100, 4, 1, 0);
      send(11'h020, 11'h100, 4, 0, 0);
      wait_idle();

      send(11'h300, 11'h340, 1, 1, 1);
      send(11'h7FE, 11'h7FF, 4, 1, 1);
      wait_idle();
      chk("done_count_directed", n_done, exp_done);

      d0 = n_done;
      n0 = exp_done;
      for (int k = 0; k < 40; k++)
         send(AW'($urandom), AW'($urandom), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
      chk("done_count_random", n_done - d0, exp_done - n0);

      i0 = n_iss;
      send(11'h050, 11'h150, 5, 1, 0);
      for (int t = 0; t < 100 && n_iss - i0 < 2; t++) begin
         @(negedge clk);
         #2;
      end
      rst = 1;
      #1 reset_chk("midrst");
      mem_init = 1;
      repeat (2) @(posedge clk);
      mem_init = 0;
      for (int a = 0; a < NA; a++) ref3[a] = ini3[a];
      @(negedge clk);
      rst = 0;
      repeat (10) @(negedge clk);
      chk("midrst_ready", cmd_ready, 1);
      i0 = n_iss;
      d0 = n_done;
      send(11'h060, 11'h160, 0, 1, 0);
      wait_idle();
      chk("zero_no_read", n_iss - i0, 0);
      chk("zero_done", n_done - d0, 1);

      send(11'h020, 11'h100, 3, 0, 1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
